// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IMEM program loader: default geometry,
// state encoding, data types and the header validity check.
package imem_loader_pkg;

  localparam int DEPTH_DEF      = 64;
  localparam int ADDR_W_DEF     = 6;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = 4;

  // Loader state encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_HDR  = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_DONE = 3'd3;
  localparam state_t S_ERR  = 3'd4;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] waddr_t;

  // A header (word count) is usable when it is non-zero and fits in IMEM.
  function automatic logic hdr_ok(input logic [7:0] n, input int depth);
    return (n != 8'd0) && (int'({24'd0, n}) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: inbound byte stream (valid/ready) plus the outbound
// word-addressed IMEM write port. master = host side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer. Holds the first three bytes of a word;
// the fourth byte is combined on the fly so word_ready/word are valid in
// the same cycle that byte is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] in_byte,
  output logic       word_ready,
  output word_t      word
);

  localparam int HELD_BYTES = BYTES_PER_WORD - 1;

  logic [1:0]              byte_idx_reg;
  logic [8*HELD_BYTES-1:0] shift_reg;

  // Byte position counter, wraps 3 -> 0 after each complete word
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx_reg <= 2'd0;
    end else if (accept) begin
      byte_idx_reg <= byte_idx_reg + 2'd1;
    end
  end

  // One holding register per low byte lane; byte k lands in bits [8k+7:8k]
  generate
    for (genvar gi = 0; gi < HELD_BYTES; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          shift_reg[8*gi +: 8] <= 8'd0;
        end else if (accept && (byte_idx_reg == 2'(gi))) begin
          shift_reg[8*gi +: 8] <= in_byte;
        end
      end
    end
  endgenerate

  assign word_ready = accept && (byte_idx_reg == 2'd3);
  assign word       = {in_byte, shift_reg};

endmodule

// File: rtl/imem_loader.sv
// IMEM program loader: reads a word-count header then N little-endian
// words from a byte stream, writes them to IMEM and keeps the CPU in
// reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W:0]   n_reg;
  logic [ADDR_W-1:0] word_idx_reg;
  logic              imem_we_reg;
  logic [ADDR_W-1:0] imem_waddr_reg;
  logic [DATA_W-1:0] imem_wdata_reg;
  logic [ADDR_W:0]   words_loaded_reg;

  logic              in_ready;
  logic              accept;
  logic              data_accept;
  logic              header_good;
  logic              word_ready;
  word_t             packed_word;
  logic [ADDR_W:0]   idx_plus1;
  logic              last_word;
  logic              restart;

  assign in_ready    = (state_reg == S_HDR) || (state_reg == S_DATA);
  assign accept      = bus.in_valid && in_ready;
  assign data_accept = accept && (state_reg == S_DATA);
  assign header_good = hdr_ok(bus.in_data, DEPTH);
  assign idx_plus1   = {1'b0, word_idx_reg} + (ADDR_W+1)'(1);
  assign last_word   = (idx_plus1 == n_reg);
  // start only matters where a load is not in progress
  assign restart     = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                 (state_reg == S_ERR));

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_reg != S_DATA),
    .accept     (data_accept),
    .in_byte    (bus.in_data),
    .word_ready (word_ready),
    .word       (packed_word)
  );

  // Next-state decode for the load sequence
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_HDR;
      S_HDR:   if (accept) state_next = header_good ? S_DATA : S_ERR;
      S_DATA:  if (word_ready && last_word) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_HDR;
      S_ERR:   if (start) state_next = S_HDR;
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Word count latch from a good header
  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg <= '0;
    end else if ((state_reg == S_HDR) && accept && header_good) begin
      n_reg <= bus.in_data[ADDR_W:0];
    end
  end

  // Word index and progress counter; index stops at N-1 instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx_reg     <= '0;
      words_loaded_reg <= '0;
    end else if ((state_reg == S_IDLE) || restart) begin
      word_idx_reg     <= '0;
      words_loaded_reg <= '0;
    end else if ((state_reg == S_HDR) && accept) begin
      word_idx_reg     <= '0;
    end else if (word_ready) begin
      if (!last_word) begin
        word_idx_reg <= word_idx_reg + ADDR_W'(1);
      end
      words_loaded_reg <= words_loaded_reg + (ADDR_W+1)'(1);
    end
  end

  // IMEM write port: one-cycle strobe registered with the completed word
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we_reg    <= 1'b0;
      imem_waddr_reg <= '0;
      imem_wdata_reg <= '0;
    end else begin
      imem_we_reg <= word_ready;
      if (word_ready) begin
        imem_waddr_reg <= word_idx_reg;
        imem_wdata_reg <= DATA_W'(packed_word);
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = imem_we_reg;
  assign bus.imem_waddr = imem_waddr_reg;
  assign bus.imem_wdata = imem_wdata_reg;

  assign cpu_hold     = (state_reg != S_DONE);
  assign done         = (state_reg == S_DONE);
  assign error        = (state_reg == S_ERR);
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected IMEM writes are queued as
// each word's last byte is handshaken and checked by a strobe monitor.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            cpu_hold;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strobes  = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                c;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every imem_we cycle must match the oldest queued word
  always @(negedge clk) begin
    exp_t e;
    if (bus.imem_we === 1'b1) begin
      strobes++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 bus.imem_waddr, bus.imem_wdata);
      end else begin
        e = sb.pop_front();
        if (bus.imem_waddr !== e.a || bus.imem_wdata !== e.d || cyc != e.c) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   bus.imem_waddr, bus.imem_wdata, cyc, e.a, e.d, e.c);
        end else begin
          $display("write addr=%0d data=%h cyc=%0d", bus.imem_waddr, bus.imem_wdata, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns the cycle of acceptance
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    bit got = 0;
    acc = -1;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk); #1;
        acc = cyc;
        got = 1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL byte_accept: byte %h not accepted within 200 cycles, required acceptance", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a, input int max_gap);
    int acc;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, acc);
      if (k == 3) begin
        e.a = a; e.d = w; e.c = acc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_drained(input string tag);
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes: got %0d pending, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks += 8;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
    if (bus.imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b required 0", bus.imem_we); end
    if (bus.imem_waddr !== '0) begin n_fail++; $display("FAIL rst_waddr: got %0d required 0", bus.imem_waddr); end
    if (bus.imem_wdata !== '0) begin n_fail++; $display("FAIL rst_wdata: got %h required 0", bus.imem_wdata); end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_hold: got %b required 1", cpu_hold); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b required 0", error); end
    if (words_loaded !== '0) begin n_fail++; $display("FAIL rst_words: got %0d required 0", words_loaded); end
  endtask

  task automatic test_basic();
    int acc;
    pulse_start();
    send_byte(8'h02, 0, acc);
    send_word(32'h20080020, 6'd0, 0);
    send_word(32'h20090037, 6'd1, 0);
    check_drained("basic");
    n_checks += 3;
    if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b required 1", done); end
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_hold: got %b required 0", cpu_hold); end
    if (words_loaded !== 7'd2) begin n_fail++; $display("FAIL basic_words: got %0d required 2", words_loaded); end
  endtask

  task automatic test_reload();
    int acc;
    pulse_start();
    n_checks += 3;
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reload_cpu_hold: got %b required 1", cpu_hold); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reload_done: got %b required 0", done); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reload_hdr_ready: got %b required 1", bus.in_ready); end
    send_byte(8'h02, 0, acc);
    send_byte(8'h11, 0, acc);
    send_byte(8'h22, 0, acc);
    pulse_start();
    n_checks++;
    if (bus.in_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL reload_start_in_data: got ready=%b done=%b required ready=1 done=0", bus.in_ready, done);
    end
    begin
      exp_t e;
      send_byte(8'h33, 0, acc);
      send_byte(8'h44, 0, acc);
      e.a = 6'd0; e.d = 32'h44332211; e.c = acc;
      sb.push_back(e);
    end
    send_word(32'hDEADBEEF, 6'd1, 0);
    check_drained("reload");
    n_checks++;
    if (done !== 1'b1 || words_loaded !== 7'd2) begin
      n_fail++; $display("FAIL reload_end: got done=%b words=%0d required done=1 words=2", done, words_loaded);
    end
  endtask

  task automatic test_bad_header();
    int acc;
    int s0;
    s0 = strobes;
    pulse_start();
    send_byte(8'h00, 0, acc);
    @(negedge clk);
    n_checks += 3;
    if (error !== 1'b1) begin n_fail++; $display("FAIL hdr0_error: got %b required 1", error); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hdr0_ready: got %b required 0", bus.in_ready); end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL hdr0_cpu_hold: got %b required 1", cpu_hold); end
    pulse_start();
    send_byte(8'h41, 0, acc);
    repeat (3) @(negedge clk);
    n_checks += 2;
    if (error !== 1'b1) begin n_fail++; $display("FAIL hdr65_error: got %b required 1", error); end
    if (strobes != s0) begin n_fail++; $display("FAIL hdr_no_write: got %0d writes required 0", strobes - s0); end
    pulse_start();
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL hdr_error_clear: got %b required 0", error); end
    send_byte(8'h01, 0, acc);
    send_word(32'h0BADC0DE, 6'd0, 0);
    check_drained("hdr_recover");
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL hdr_recover_done: got done=%b error=%b required done=1 error=0", done, error);
    end
  endtask

  task automatic test_stall();
    int acc;
    pulse_start();
    send_byte(8'h03, 2, acc);
    for (int i = 0; i < 3; i++) begin
      send_word($urandom, 6'(i), 4);
    end
    check_drained("stall");
    n_checks++;
    if (done !== 1'b1 || words_loaded !== 7'd3) begin
      n_fail++; $display("FAIL stall_end: got done=%b words=%0d required done=1 words=3", done, words_loaded);
    end
  endtask

  task automatic test_full_depth();
    int acc;
    int s0;
    s0 = strobes;
    pulse_start();
    send_byte(8'h40, 0, acc);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(32'(i), 6'(i), 0);
    end
    check_drained("full");
    n_checks += 3;
    if (words_loaded !== 7'd64) begin n_fail++; $display("FAIL full_words: got %0d required 64", words_loaded); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b required 1", done); end
    if (strobes - s0 != 64) begin n_fail++; $display("FAIL full_count: got %0d required 64", strobes - s0); end
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_extra_byte: got in_ready=%b required 0", bus.in_ready); end
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc;
    int s0;
    s0 = strobes;
    pulse_start();
    send_byte(8'h04, 0, acc);
    send_word(32'hA1A2A3A4, 6'd0, 0);
    send_word(32'hB1B2B3B4, 6'd1, 0);
    send_byte(8'hC4, 0, acc);
    send_byte(8'hC3, 0, acc);
    do_reset();
    @(negedge clk);
    n_checks += 7;
    if (strobes - s0 != 2) begin n_fail++; $display("FAIL mid_count: got %0d required 2", strobes - s0); end
    if (bus.imem_we !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_we_ready: got we=%b ready=%b required 0 0", bus.imem_we, bus.in_ready);
    end
    if (bus.imem_waddr !== '0) begin n_fail++; $display("FAIL mid_waddr: got %0d required 0", bus.imem_waddr); end
    if (bus.imem_wdata !== '0) begin n_fail++; $display("FAIL mid_wdata: got %h required 0", bus.imem_wdata); end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_hold: got %b required 1", cpu_hold); end
    if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got done=%b error=%b required 0 0", done, error); end
    if (words_loaded !== '0) begin n_fail++; $display("FAIL mid_words: got %0d required 0", words_loaded); end
    pulse_start();
    send_byte(8'h01, 0, acc);
    send_word(32'hCAFEF00D, 6'd0, 0);
    check_drained("mid_reload");
    n_checks++;
    if (done !== 1'b1 || words_loaded !== 7'd1) begin
      n_fail++; $display("FAIL mid_reload_end: got done=%b words=%0d required done=1 words=1", done, words_loaded);
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    test_reset();
    test_basic();
    test_reload();
    test_bad_header();
    test_stall();
    test_full_depth();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
